// File: rtl/gf2m_digit_feeder.sv
// gf2m_digit_feeder
//
// Operand sequencer in front of the digit-serial GF(2^m) multiplier. It takes
// one full-width request (a, b, g), pulses the multiplier start, then streams b
// one DIGITAL-bit digit per cycle, most significant digit first. The product is
// captured on the multiplier's done pulse and held until the consumer takes it.
// If done never arrives within TIMEOUT wait cycles, a zero result is flagged
// with res_err.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready request handshake; req_a, req_b, req_g operands
//   res_valid/res_ready result handshake; res_data product, res_err timeout
//   mul_start           one-cycle start pulse to the multiplier
//   mul_a, mul_g        latched a and g, driven from issue through wait
//   mul_b               current digit of b (zero outside the feed phase)
//   mul_done            multiplier done pulse (only honoured while waiting)
//   mul_result          multiplier product, valid only while mul_done is high
module gf2m_digit_feeder #(
  parameter int DIGITAL    = 64,
  parameter int DATA_WIDTH = 163,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  input  logic [DATA_WIDTH-1:0] req_g,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_err,
  output logic                  mul_start,
  output logic [DATA_WIDTH-1:0] mul_a,
  output logic [DATA_WIDTH-1:0] mul_g,
  output logic [DIGITAL-1:0]    mul_b,
  input  logic                  mul_done,
  input  logic [DATA_WIDTH-1:0] mul_result
);

  localparam int ITER = DATA_WIDTH / DIGITAL + 1;
  localparam int PADW = ITER * DIGITAL;
  localparam int KW   = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_FEED,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] a_reg, g_reg;
  // b zero-extended to PADW; shifted left once per feed cycle so the current
  // digit is always the top DIGITAL bits.
  logic [PADW-1:0]       b_sh_reg;
  logic [KW-1:0]         k_reg;
  logic [7:0]            tcnt_reg;
  logic [DATA_WIDTH-1:0] res_data_reg;
  logic                  res_err_reg;

  logic last_digit;
  logic timeout_hit;

  assign last_digit  = (k_reg == KW'(ITER - 1));
  // The counter holds the number of done-less wait cycles already spent; the
  // TIMEOUT-th such cycle ends the wait.
  assign timeout_hit = (tcnt_reg == 8'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE:  if (req_valid) state_next = S_ISSUE;
      S_ISSUE: state_next = S_FEED;
      S_FEED:  if (last_digit) state_next = S_WAIT;
      S_WAIT:  if (mul_done || timeout_hit) state_next = S_HOLD;
      S_HOLD:  if (res_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    req_ready = 1'b0;
    res_valid = 1'b0;
    mul_start = 1'b0;
    mul_b     = '0;
    mul_a     = '0;
    mul_g     = '0;
    unique case (state_reg)
      S_IDLE:  req_ready = 1'b1;
      S_ISSUE: begin
        mul_start = 1'b1;
        mul_a     = a_reg;
        mul_g     = g_reg;
      end
      S_FEED: begin
        mul_b = b_sh_reg[PADW-1 -: DIGITAL];
        mul_a = a_reg;
        mul_g = g_reg;
      end
      S_WAIT: begin
        mul_a = a_reg;
        mul_g = g_reg;
      end
      S_HOLD:  res_valid = 1'b1;
      default: ;
    endcase
  end

  assign res_data = res_data_reg;
  assign res_err  = res_err_reg;

  // Operand latch, digit shifter, timeout counter and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg        <= '0;
      g_reg        <= '0;
      b_sh_reg     <= '0;
      k_reg        <= '0;
      tcnt_reg     <= '0;
      res_data_reg <= '0;
      res_err_reg  <= 1'b0;
    end else begin
      unique case (state_reg)
        S_IDLE: begin
          if (req_valid) begin
            a_reg    <= req_a;
            g_reg    <= req_g;
            b_sh_reg <= PADW'(req_b);
            k_reg    <= '0;
            tcnt_reg <= '0;
          end
        end
        S_FEED: begin
          b_sh_reg <= b_sh_reg << DIGITAL;
          k_reg    <= k_reg + KW'(1);
        end
        S_WAIT: begin
          // mul_result is only valid during the done cycle, so capture here.
          if (mul_done) begin
            res_data_reg <= mul_result;
            res_err_reg  <= 1'b0;
          end else begin
            tcnt_reg <= tcnt_reg + 8'd1;
            if (timeout_hit) begin
              res_data_reg <= '0;
              res_err_reg  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf2m_digit_feeder.sv
`timescale 1ns/1ps
module tb_gf2m_digit_feeder;

  localparam int DIGITAL = 64;
  localparam int DW      = 163;
  localparam int TIMEOUT = 15;
  localparam int ITER    = DW / DIGITAL + 1;
  localparam int PADW    = ITER * DIGITAL;
  localparam int NEVER   = 255;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [DW-1:0]   req_a = '0, req_b = '0, req_g = '0;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [DW-1:0]   res_data;
  logic            res_err;
  logic            mul_start;
  logic [DW-1:0]   mul_a, mul_g;
  logic [DIGITAL-1:0] mul_b;
  logic            mul_done = 1'b0;
  logic [DW-1:0]   mul_result = '0;

  int n_vec = 0;
  int n_bad = 0;
  int cur_delay = 0;   // done delay (cycles after last digit) the stub will use

  always #5 clk = ~clk;

  gf2m_digit_feeder #(
    .DIGITAL(DIGITAL), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_g(req_g),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_g(mul_g), .mul_b(mul_b),
    .mul_done(mul_done), .mul_result(mul_result)
  );

  task automatic chk(input string name, input logic [PADW-1:0] act, input logic [PADW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Field multiply modulo x^DW + g (g holds the low-order terms).
  function automatic logic [DW-1:0] gf_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [DW-1:0] g);
    logic [DW-1:0] acc;
    logic [DW-1:0] x;
    acc = '0;
    x = a;
    for (int i = 0; i < DW; i++) begin
      if (b[i]) acc = acc ^ x;
      x = x[DW-1] ? ((x << 1) ^ g) : (x << 1);
    end
    return acc;
  endfunction

  function automatic logic [DW-1:0] rand_wide();
    logic [191:0] r;
    for (int i = 0; i < 6; i++) r[i*32 +: 32] = $urandom();
    return r[DW-1:0];
  endfunction

  // ---------------- behavioural model: timeline since acceptance ----------------
  logic            m_busy = 1'b0;
  int              m_t = 0;     // edges since acceptance edge
  int              m_lat = 0;   // edge index at which the result is held
  logic [DW-1:0]   m_a = '0, m_g = '0, m_res = '0;
  logic [PADW-1:0] m_bpad = '0;
  logic            m_err = 1'b0;

  task automatic model_step();
    if (rst) begin
      m_busy = 1'b0;
      return;
    end
    if (!m_busy) begin
      if (req_valid) begin
        m_busy = 1'b1;
        m_t    = 0;
        m_a    = req_a;
        m_g    = req_g;
        m_bpad = PADW'(req_b);
        m_err  = (cur_delay >= TIMEOUT);
        m_res  = m_err ? '0 : gf_mul(req_a, req_b, req_g);
        m_lat  = ITER + 2 + (m_err ? TIMEOUT - 1 : cur_delay);
      end
    end else if (m_t >= m_lat) begin
      if (res_ready) m_busy = 1'b0;
    end else begin
      m_t++;
    end
  endtask

  // ---------------- multiplier stub ----------------
  logic            s_act = 1'b0;
  int              s_t = 0;
  int              s_d = 0;
  logic [DW-1:0]   s_a = '0, s_g = '0;
  logic [PADW-1:0] s_b = '0;

  task automatic stub_step();
    mul_done   = 1'b0;
    mul_result = rand_wide();   // garbage outside the done cycle
    if (rst) begin
      s_act = 1'b0;
      return;
    end
    if (mul_start) begin
      s_act = 1'b1;
      s_t   = 0;
      s_d   = cur_delay;
      s_a   = mul_a;
      s_g   = mul_g;
      s_b   = '0;
    end else if (s_act) begin
      s_t++;
      if (s_t <= ITER) s_b = (s_b << DIGITAL) | PADW'(mul_b);
      if (s_d != NEVER && s_t == ITER + 1 + s_d) begin
        mul_done   = 1'b1;
        mul_result = gf_mul(s_a, DW'(s_b), s_g);
        s_act      = 1'b0;
      end else if (s_t > ITER + TIMEOUT + 3) begin
        s_act = 1'b0;
      end
    end else if ($urandom_range(0, 7) == 0) begin
      mul_done = 1'b1;          // stray done while no operation is outstanding
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
    stub_step();
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin : cmp
    logic [PADW-1:0] sh;
    logic [DIGITAL-1:0] exp_b;
    if (!m_busy) begin
      chk("idle_req_ready", req_ready, 1);
      chk("idle_res_valid", res_valid, 0);
      chk("idle_mul_start", mul_start, 0);
      chk("idle_mul_b", mul_b, 0);
      chk("idle_mul_a", mul_a, 0);
      chk("idle_mul_g", mul_g, 0);
    end else begin
      chk("busy_req_ready", req_ready, 0);
      chk("mul_start", mul_start, (m_t == 0));
      chk("res_valid", res_valid, (m_t >= m_lat));
      if (m_t >= m_lat) begin
        chk("res_data", res_data, m_res);
        chk("res_err", res_err, m_err);
        chk("hold_mul_b", mul_b, 0);
      end else begin
        chk("mul_a", mul_a, m_a);
        chk("mul_g", mul_g, m_g);
        exp_b = '0;
        if (m_t >= 1 && m_t <= ITER) begin
          sh    = m_bpad >> (PADW - m_t * DIGITAL);
          exp_b = sh[DIGITAL-1:0];
        end
        chk("mul_b", mul_b, exp_b);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic accept(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] g, input int d);
    req_a = a; req_b = b; req_g = g; cur_delay = d; req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (m_busy && m_t == 0) break;
    end
    req_valid = 1'b0;
    chk("accept_start", mul_start, 1);
    $display("op a=%0h b=%0h g=%0h delay=%0d", a, b, g, d);
  endtask

  task automatic wait_res(output int lat);
    lat = 0;
    while (lat < 60) begin
      step();
      lat++;
      if (res_valid) break;
    end
    chk("res_valid_seen", res_valid, 1);
  endtask

  task automatic drain();
    res_ready = 1'b1;
    step();
  endtask

  initial begin
    int lat;
    int r;
    logic [DW-1:0] bb;
    logic [DW-1:0] held;

    repeat (3) step();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_g", mul_g, 0);
    chk("rst_mul_b", mul_b, 0);
    rst = 1'b0;
    step();

    // Latency with done in the cycle after the last digit
    res_ready = 1'b1;
    accept(DW'(16'h1234), DW'(1), DW'(8'hC9), 0);
    wait_res(lat);
    chk("latency", lat, 5);
    chk("latency_data", res_data, DW'(16'h1234));
    chk("latency_err", res_err, 0);
    drain();

    // Digit order
    bb = '0;
    bb[162:128] = 35'h5;
    bb[127:64]  = 64'h2;
    bb[63:0]    = 64'h1;
    accept(rand_wide(), bb, DW'(8'hC9), 0);
    chk("dig_issue_b", mul_b, 0);
    step(); chk("dig0", mul_b, 64'h5); chk("dig0_start", mul_start, 0);
    step(); chk("dig1", mul_b, 64'h2);
    step(); chk("dig2", mul_b, 64'h1);
    step(); chk("dig_wait_b", mul_b, 0);
    wait_res(lat);
    drain();

    // Timeout and its boundaries
    accept(rand_wide(), rand_wide(), rand_wide(), NEVER);
    wait_res(lat);
    chk("timeout_lat", lat, 19);
    chk("timeout_err", res_err, 1);
    chk("timeout_data", res_data, 0);
    drain();
    accept(rand_wide(), rand_wide(), rand_wide(), TIMEOUT - 1);
    wait_res(lat);
    chk("late_done_lat", lat, 19);
    chk("late_done_err", res_err, 0);
    drain();
    accept(rand_wide(), rand_wide(), rand_wide(), TIMEOUT);
    wait_res(lat);
    chk("too_late_err", res_err, 1);
    drain();

    // Field products
    accept(DW'(1), DW'(1), DW'(8'hC9), 0);
    wait_res(lat);
    chk("gf_1x1", res_data, DW'(1));
    drain();
    bb = '0;
    bb[162] = 1'b1;
    accept(DW'(2), bb, DW'(8'hC9), 0);
    wait_res(lat);
    chk("gf_2xtop", res_data, DW'(8'hC9));
    drain();

    // Backpressure with a second request waiting
    res_ready = 1'b0;
    accept(rand_wide(), rand_wide(), rand_wide(), 0);
    wait_res(lat);
    held = res_data;
    req_a = rand_wide(); req_b = rand_wide(); req_g = rand_wide();
    cur_delay = 0; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_data_stable", res_data, held);
      chk("bp_req_ready", req_ready, 0);
    end
    res_ready = 1'b1;
    step();
    chk("bp_after_hs_ready", req_ready, 1);
    chk("bp_after_hs_start", mul_start, 0);
    step();
    chk("bp_second_accept", mul_start, 1);
    req_valid = 1'b0;
    wait_res(lat);
    drain();

    // Reset during digit 1
    accept(rand_wide(), rand_wide(), rand_wide(), 0);
    step();
    step();
    #2;
    rst = 1'b1;
    m_busy = 1'b0;
    s_act = 1'b0;
    mul_done = 1'b0;
    #1;
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_res_err", res_err, 0);
    chk("mid_rst_mul_start", mul_start, 0);
    chk("mid_rst_res_data", res_data, 0);
    chk("mid_rst_mul_a", mul_a, 0);
    chk("mid_rst_mul_g", mul_g, 0);
    chk("mid_rst_mul_b", mul_b, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("post_rst_ready", req_ready, 1);
      chk("post_rst_no_res", res_valid, 0);
    end

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      req_valid = ($urandom_range(0, 9) < 7);
      req_a = rand_wide();
      req_b = rand_wide();
      req_g = ($urandom_range(0, 3) == 0) ? DW'(8'hC9) : rand_wide();
      r = $urandom_range(0, 9);
      cur_delay = (r < 6) ? 0 : ((r < 9) ? int'($urandom_range(0, TIMEOUT + 1)) : NEVER);
      res_ready = $urandom_range(0, 1);
      step();
      if (res_valid && res_ready)
        $display("res data=%0h err=%0b", res_data, res_err);
    end
    req_valid = 1'b0;
    res_ready = 1'b1;
    repeat (40) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
